// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder ripple-carry adder.
package full_adder_pkg;
  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_STAGES        = 1;
endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder cell: the ripple element of full_adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder built from 1-bit cells, with combinational
// sum/carry/overflow and a registered, enable-gated copy of the result.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             en,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic [WIDTH-1:0] Sum_q,
  output logic             Cout_q,
  output logic             Ovf_q,
  output logic             valid_q
);
  logic [WIDTH:0]     carry;
  logic [FA_STAGES:0] vld_pipe;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .c  (carry[i]),
      .s  (Sum[i]),
      .co (carry[i+1])
    );
  end

  assign Cout = carry[WIDTH];
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign Ovf  = carry[WIDTH-1] ^ carry[WIDTH];

  assign vld_pipe[0] = en;
  assign valid_q     = vld_pipe[FA_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sum_q              <= '0;
      Cout_q             <= 1'b0;
      Ovf_q              <= 1'b0;
      vld_pipe[FA_STAGES:1] <= '0;
    end else begin
      vld_pipe[FA_STAGES:1] <= vld_pipe[FA_STAGES-1:0];
      if (en) begin
        Sum_q  <= Sum;
        Cout_q <= Cout;
        Ovf_q  <= Ovf;
      end
    end
  end
endmodule

// File: tb/tb_full_adder.sv
// Directed and table-driven bench for full_adder at WIDTH 1, 4 and 8.
module tb_full_adder;
  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst = 1'b0;

  logic       a1 = 0, b1 = 0, c1 = 0, en1 = 0;
  logic       s1, co1, ov1, sq1, coq1, ovq1, vq1;
  logic [3:0] a4 = 0, b4 = 0, s4, sq4;
  logic       c4 = 0, en4 = 0, co4, ov4, coq4, ovq4, vq4;
  logic [7:0] a8 = 0, b8 = 0, s8, sq8;
  logic       c8 = 0, en8 = 0, co8, ov8, coq8, ovq8, vq8;

  int total = 0;
  int bad   = 0;

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1), .en(en1),
    .Sum(s1), .Cout(co1), .Ovf(ov1),
    .Sum_q(sq1), .Cout_q(coq1), .Ovf_q(ovq1), .valid_q(vq1));

  full_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(c4), .en(en4),
    .Sum(s4), .Cout(co4), .Ovf(ov4),
    .Sum_q(sq4), .Cout_q(coq4), .Ovf_q(ovq4), .valid_q(vq4));

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(c8), .en(en8),
    .Sum(s8), .Cout(co8), .Ovf(ov8),
    .Sum_q(sq8), .Cout_q(coq8), .Ovf_q(ovq8), .valid_q(vq8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic a, b, c;
    logic s, co;
  } vec1_t;

  vec1_t tv[8];

  initial begin
    logic [8:0] ref9;
    int         sref;
    logic [7:0] esq;
    logic       ecoq, eovq, evq;

    // hand-computed 1-bit truth table, ascending {A,B,Cin}
    tv[0] = '{0,0,0, 0,0};
    tv[1] = '{0,0,1, 1,0};
    tv[2] = '{0,1,0, 1,0};
    tv[3] = '{0,1,1, 0,1};
    tv[4] = '{1,0,0, 1,0};
    tv[5] = '{1,0,1, 0,1};
    tv[6] = '{1,1,0, 0,1};
    tv[7] = '{1,1,1, 1,1};

    // exhaustive 1-bit, clock idle, reset never asserted
    for (int i = 0; i < 8; i++) begin
      a1 = tv[i].a; b1 = tv[i].b; c1 = tv[i].c;
      #10;
      chk($sformatf("tt%0d_sum", i),  s1,  tv[i].s);
      chk($sformatf("tt%0d_cout", i), co1, tv[i].co);
      chk($sformatf("tt%0d_ovf", i),  ov1, tv[i].c ^ tv[i].co);
    end

    // WIDTH=4 wrap-around and signed overflow
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1; #1;
    chk("w4_wrap_sum", s4, 4'hF);
    chk("w4_wrap_cout", co4, 1'b1);
    chk("w4_wrap_ovf", ov4, 1'b0);
    a4 = 4'h7; b4 = 4'h1; c4 = 1'b0; #1;
    chk("w4_ovf_sum", s4, 4'h8);
    chk("w4_ovf_cout", co4, 1'b0);
    chk("w4_ovf_ovf", ov4, 1'b1);

    // registered capture, then hold with en low
    clk_run = 1'b1;
    @(negedge clk);
    a1 = 1; b1 = 1; c1 = 0; en1 = 1;
    @(posedge clk); #1;
    chk("cap_sum_q", sq1, 1'b0);
    chk("cap_cout_q", coq1, 1'b1);
    chk("cap_valid_q", vq1, 1'b1);
    @(negedge clk);
    en1 = 0; a1 = 0;
    @(posedge clk); #1;
    chk("hold_sum_q", sq1, 1'b0);
    chk("hold_cout_q", coq1, 1'b1);
    chk("hold_valid_q", vq1, 1'b0);

    // asynchronous reset mid-cycle
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("rst_sum_q", sq1, 1'b0);
    chk("rst_cout_q", coq1, 1'b0);
    chk("rst_ovf_q", ovq1, 1'b0);
    chk("rst_valid_q", vq1, 1'b0);
    a1 = 1; b1 = 0; c1 = 0; en1 = 1; #1;
    chk("rst_comb_sum", s1, 1'b1);
    chk("rst_comb_cout", co1, 1'b0);
    @(posedge clk); #1;
    chk("rst_held_cout_q", coq1, 1'b0);
    chk("rst_held_valid_q", vq1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // load a nonzero result, then collide reset with the clock edge
    a1 = 1; b1 = 1; c1 = 1; en1 = 1;
    @(posedge clk); #1;
    chk("pre_col_sum_q", sq1, 1'b1);
    chk("pre_col_cout_q", coq1, 1'b1);
    @(negedge clk); #5;
    rst = 1'b1; #1;
    chk("col_sum_q", sq1, 1'b0);
    chk("col_cout_q", coq1, 1'b0);
    chk("col_valid_q", vq1, 1'b0);
    @(negedge clk);
    rst = 1'b0; en1 = 0;

    // WIDTH=8 random, registers start from reset
    esq = '0; ecoq = 0; eovq = 0; evq = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      c8  = 1'($urandom);
      en8 = 1'($urandom);
      #1;
      ref9 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
      sref = $signed(a8) + $signed(b8) + int'(c8);
      chk("rnd_sum", s8, ref9[7:0]);
      chk("rnd_cout", co8, ref9[8]);
      chk("rnd_ovf", ov8, (sref > 127 || sref < -128) ? 1'b1 : 1'b0);
      if (en8) begin
        esq = ref9[7:0]; ecoq = ref9[8];
        eovq = (sref > 127 || sref < -128) ? 1'b1 : 1'b0;
      end
      evq = en8;
      @(posedge clk); #1;
      chk("rnd_sum_q", sq8, esq);
      chk("rnd_cout_q", coq8, ecoq);
      chk("rnd_ovf_q", ovq8, eovq);
      chk("rnd_valid_q", vq8, evq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
